expression_stack: RTL and testbench
===================================

Name: expression_stack

Overview:
- Expression-stack datapath that executes the stack commands issued by the control unit: ESAct, ESOp, popAmt and dupNum.
- Holds up to DEPTH operand words.
- Presents the top two entries to the ALU and push-source muxes.
- Flags illegal commands without corrupting state.

Parameters:
WIDTH, 16, data word width
DEPTH, 16, number of stack entries (power of two, >=4)
CW, $clog2(DEPTH)+1, width of the depth count (derived; do not override)

Ports:
CLK  input  1  system clock, all state changes on rising edge
Reset  input  1  asynchronous active-low reset
ESAct  input  1  command strobe; ESOp is ignored when 0
ESOp  input  2  00 PUSH, 01 POP, 10 DUP, 11 REPLACE
popAmt  input  1  entries removed by POP/REPLACE = popAmt+1
dupNum  input  2  DUP source index, 0 = top, 3 = fourth from top
push_data  input  WIDTH  word for PUSH/REPLACE (already selected by PushSrc mux upstream)
err_clr  input  1  synchronous clear of sticky error flags
top  output  WIDTH  entry at depth-1; 0 when empty
second  output  WIDTH  entry at depth-2; 0 when depth<2
depth  output  CW  current entry count, 0..DEPTH
full  output  1  depth==DEPTH
empty  output  1  depth==0
overflow  output  1  sticky: rejected command would exceed DEPTH
underflow  output  1  sticky: rejected command needed more entries than present
ack  output  1  one-cycle pulse, command accepted in previous cycle

Behaviour:
- Reset low, asynchronously:
  - depth=0, overflow=0, underflow=0, ack=0; hence empty=1, full=0, top=0, second=0.
  - Storage array is not cleared; reads are gated by depth.
- Storage: register array indexed 0..DEPTH-1, where index depth-1 is the top.
- top, second, full and empty are combinational from depth and storage. They reflect a command on the edge after it is sampled (1-cycle latency).
- Commands are sampled on the rising edge when ESAct=1. ESAct=0 means hold: no change, ack=0.
- PUSH: legal if depth<DEPTH. mem[depth] <= push_data, depth+1.
- POP: legal if depth >= popAmt+1. depth - (popAmt+1); data is not erased.
- DUP: legal if depth > dupNum and depth < DEPTH. mem[depth] <= mem[depth-1-dupNum], depth+1.
- REPLACE (ALU writeback): legal if depth >= popAmt+1.
  - mem[depth-1-popAmt] <= push_data; depth - popAmt.
  - popAmt=0 is a unary op and depth is unchanged; popAmt=1 is a binary op and depth drops by 1.
  - Never overflows.
- Accepted command: ack=1 for exactly the next cycle.
- Rejected command:
  - Stack state unchanged, ack=0.
  - overflow set for PUSH/DUP when full.
  - underflow set for POP/REPLACE/DUP with too few entries.
  - DUP on a full stack with dupNum >= depth sets only overflow (overflow takes priority).
- Sticky flags:
  - Hold until err_clr=1 or Reset.
  - If err_clr and a new error occur on the same edge, the new error wins (flag = 1).
- Each ESAct cycle is an independent command; back-to-back commands every cycle must be supported. DUP/REPLACE read pre-edge contents.
- Arithmetic: depth is unsigned CW bits. Indices are computed in CW bits and must never wrap; legality checks precede any index use.
- Reset asserted mid-sequence: state clears immediately. The first command after Reset rises is evaluated against depth=0.

Test Plan:
1. Reset low then high, ESAct=0 for 3 cycles -> depth=0, empty=1, top=0, second=0, ack=0, flags 0.
2. PUSH 0x0005, PUSH 0x0003, REPLACE popAmt=1 data=0x0008 -> after each edge, depth goes 1, 2, 1; then top=0x0008, ack pulses 3 times.
3. PUSH 0x0011, 0x0022, 0x0033, then DUP dupNum=2 -> depth=4, top=0x0011, second=0x0033. Then POP popAmt=1 -> depth=2, top=0x0022.
4. Push 16 words 0x0100..0x010F; 17th PUSH 0x0FFF -> full=1, depth=16, top=0x010F, overflow=1, ack=0 on rejected cycle. Then err_clr -> overflow=0.
5. Empty stack: POP popAmt=0 -> underflow=1, depth=0. Then PUSH 0x00AA and DUP dupNum=1 -> DUP rejected, depth=1, underflow stays 1.
6. Depth=3, drive Reset low mid-cycle between edges -> depth=0 and empty=1 immediately, without waiting for CLK. After release, POP -> underflow=1.

Source files
------------

// File: rtl/expression_stack.sv
// Expression-stack datapath: executes PUSH/POP/DUP/REPLACE from the control unit,
// exposes the top two entries, and records illegal commands in sticky flags.
module expression_stack #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ESAct,
    input  logic [1:0]       ESOp,
    input  logic             popAmt,
    input  logic [1:0]       dupNum,
    input  logic [WIDTH-1:0] push_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second,
    output logic [CW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             ack
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DUP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_depth;
    logic             r_ovf;
    logic             r_unf;
    logic             r_ack;

    logic [CW-1:0]    w_need;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_dup_src;
    logic             w_acc;
    logic             w_ovf_err;
    logic             w_unf_err;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [WIDTH-1:0] w_wr_data;
    logic [CW-1:0]    w_nxt_depth;

    assign w_need    = CW'(popAmt) + CW'(1);
    assign w_full    = (r_depth == CW'(DEPTH));
    assign w_empty   = (r_depth == '0);
    // Address wraps harmlessly when DUP is illegal; the result is never written then.
    assign w_dup_src = r_mem[AW'(r_depth - CW'(dupNum) - CW'(1))];

    always_comb begin
        w_acc       = 1'b0;
        w_ovf_err   = 1'b0;
        w_unf_err   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = AW'(r_depth);
        w_wr_data   = push_data;
        w_nxt_depth = r_depth;
        if (ESAct) begin
            case (ESOp)
                OP_PUSH: begin
                    if (w_full) begin
                        w_ovf_err = 1'b1;
                    end else begin
                        w_acc       = 1'b1;
                        w_wr_en     = 1'b1;
                        w_nxt_depth = r_depth + CW'(1);
                    end
                end
                OP_POP: begin
                    if (r_depth < w_need) begin
                        w_unf_err = 1'b1;
                    end else begin
                        w_acc       = 1'b1;
                        w_nxt_depth = r_depth - w_need;
                    end
                end
                OP_DUP: begin
                    // A full stack reports overflow even if the source is also missing.
                    if (w_full) begin
                        w_ovf_err = 1'b1;
                    end else if (r_depth <= CW'(dupNum)) begin
                        w_unf_err = 1'b1;
                    end else begin
                        w_acc       = 1'b1;
                        w_wr_en     = 1'b1;
                        w_wr_data   = w_dup_src;
                        w_nxt_depth = r_depth + CW'(1);
                    end
                end
                OP_REPL: begin
                    if (r_depth < w_need) begin
                        w_unf_err = 1'b1;
                    end else begin
                        w_acc       = 1'b1;
                        w_wr_en     = 1'b1;
                        w_wr_idx    = AW'(r_depth - w_need);
                        w_nxt_depth = r_depth - CW'(popAmt);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_depth <= w_nxt_depth;
            r_ack   <= w_acc;
            // A fresh error on the clearing edge must survive the clear.
            r_ovf   <= w_ovf_err | (r_ovf & ~err_clr);
            r_unf   <= w_unf_err | (r_unf & ~err_clr);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
    end

    assign top       = w_empty ? '0 : r_mem[AW'(r_depth - CW'(1))];
    assign second    = (r_depth < CW'(2)) ? '0 : r_mem[AW'(r_depth - CW'(2))];
    assign depth     = r_depth;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign ack       = r_ack;

endmodule

// File: tb/tb_expression_stack.sv
// Directed bench for expression_stack: a queue-based stack model is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_expression_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             Reset = 1'b0;
    logic             ESAct = 1'b0;
    logic [1:0]       ESOp = '0;
    logic             popAmt = 1'b0;
    logic [1:0]       dupNum = '0;
    logic [WIDTH-1:0] push_data = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] top, second;
    logic [CW-1:0]    depth;
    logic             full, empty, overflow, underflow, ack;

    int errors = 0;
    int checks = 0;

    expression_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .ESAct(ESAct), .ESOp(ESOp), .popAmt(popAmt),
        .dupNum(dupNum), .push_data(push_data), .err_clr(err_clr),
        .top(top), .second(second), .depth(depth), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .ack(ack)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: a queue whose last element is the top of stack.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    logic             m_ack = 1'b0;

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_ack = 1'b0;
        end else begin
            bit ok, eo, eu;
            int n;
            logic [WIDTH-1:0] v;
            ok = 0; eo = 0; eu = 0;
            n  = m_q.size();
            if (ESAct) begin
                case (ESOp)
                    2'b00: if (n == DEPTH) eo = 1; else begin m_q.push_back(push_data); ok = 1; end
                    2'b01: if (n < popAmt + 1) eu = 1;
                           else begin for (int k = 0; k <= popAmt; k++) void'(m_q.pop_back()); ok = 1; end
                    2'b10: if (n == DEPTH) eo = 1; else if (n <= dupNum) eu = 1;
                           else begin v = m_q[n - 1 - dupNum]; m_q.push_back(v); ok = 1; end
                    default: if (n < popAmt + 1) eu = 1;
                           else begin
                               for (int k = 0; k <= popAmt; k++) void'(m_q.pop_back());
                               m_q.push_back(push_data); ok = 1;
                           end
                endcase
            end
            m_ack = ok;
            m_ovf = eo | (m_ovf & ~err_clr);
            m_unf = eu | (m_unf & ~err_clr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge CLK) begin
        int n;
        n = m_q.size();
        chk("m.depth", int'(depth), n);
        chk("m.top", int'(top), n > 0 ? int'(m_q[n-1]) : 0);
        chk("m.second", int'(second), n > 1 ? int'(m_q[n-2]) : 0);
        chk("m.full", int'(full), int'(n == DEPTH));
        chk("m.empty", int'(empty), int'(n == 0));
        chk("m.overflow", int'(overflow), int'(m_ovf));
        chk("m.underflow", int'(underflow), int'(m_unf));
        chk("m.ack", int'(ack), int'(m_ack));
    end

    // Called at a falling edge; returns at the next falling edge, after the command's rising edge.
    task automatic cmd(input logic [1:0] op, input logic pa, input logic [1:0] dn,
                       input logic [WIDTH-1:0] d, input logic clr = 1'b0);
        ESAct = 1'b1; ESOp = op; popAmt = pa; dupNum = dn; push_data = d; err_clr = clr;
        @(negedge CLK);
        ESAct = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        #2 Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        // 1: reset then idle
        @(negedge CLK);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        chk("t1.depth", int'(depth), 0);
        chk("t1.empty", int'(empty), 1);
        chk("t1.top", int'(top), 0);
        chk("t1.second", int'(second), 0);
        chk("t1.ack", int'(ack), 0);
        chk("t1.flags", int'({overflow, underflow}), 0);

        // 2: push, push, binary REPLACE (back to back)
        cmd(2'b00, 1'b0, 2'd0, 16'h0005);
        chk("t2.depth1", int'(depth), 1); chk("t2.ack1", int'(ack), 1);
        cmd(2'b00, 1'b0, 2'd0, 16'h0003);
        chk("t2.depth2", int'(depth), 2); chk("t2.ack2", int'(ack), 1);
        cmd(2'b11, 1'b1, 2'd0, 16'h0008);
        chk("t2.depth3", int'(depth), 1); chk("t2.ack3", int'(ack), 1);
        chk("t2.top", int'(top), 16'h0008);

        // 3: DUP from third entry, then POP two
        do_reset();
        cmd(2'b00, 1'b0, 2'd0, 16'h0011);
        cmd(2'b00, 1'b0, 2'd0, 16'h0022);
        cmd(2'b00, 1'b0, 2'd0, 16'h0033);
        cmd(2'b10, 1'b0, 2'd2, 16'h0000);
        chk("t3.depth", int'(depth), 4);
        chk("t3.top", int'(top), 16'h0011);
        chk("t3.second", int'(second), 16'h0033);
        cmd(2'b11, 1'b0, 2'd0, 16'h0044);
        chk("t3.unary_top", int'(top), 16'h0044);
        chk("t3.unary_depth", int'(depth), 4);
        cmd(2'b01, 1'b1, 2'd0, 16'h0000);
        chk("t3.pop_depth", int'(depth), 2);
        chk("t3.pop_top", int'(top), 16'h0022);

        // 4: fill to capacity, overflow, clear, error racing a clear
        do_reset();
        for (int i = 0; i < DEPTH; i++) cmd(2'b00, 1'b0, 2'd0, WIDTH'(16'h0100 + i));
        cmd(2'b00, 1'b0, 2'd0, 16'h0FFF);
        chk("t4.full", int'(full), 1);
        chk("t4.depth", int'(depth), 16);
        chk("t4.top", int'(top), 16'h010F);
        chk("t4.overflow", int'(overflow), 1);
        chk("t4.ack", int'(ack), 0);
        cmd(2'b00, 1'b0, 2'd0, 16'h0000, 1'b0);
        ESAct = 1'b0; err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        chk("t4.clr", int'(overflow), 0);
        cmd(2'b10, 1'b0, 2'd3, 16'h0000, 1'b1);
        chk("t4.err_wins", int'(overflow), 1);
        cmd(2'b01, 1'b0, 2'd0, 16'h0000);
        cmd(2'b10, 1'b0, 2'd3, 16'h0000);
        chk("t4.dup_deep", int'(top), 16'h010B);

        // 5: underflow on empty, then illegal DUP
        do_reset();
        cmd(2'b01, 1'b0, 2'd0, 16'h0000);
        chk("t5.underflow", int'(underflow), 1);
        chk("t5.depth0", int'(depth), 0);
        cmd(2'b00, 1'b0, 2'd0, 16'h00AA);
        cmd(2'b10, 1'b0, 2'd1, 16'h0000);
        chk("t5.depth1", int'(depth), 1);
        chk("t5.sticky", int'(underflow), 1);
        chk("t5.ack", int'(ack), 0);

        // 6: asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) cmd(2'b00, 1'b0, 2'd0, WIDTH'(16'h0200 + i));
        chk("t6.depth3", int'(depth), 3);
        #2 Reset = 1'b0;
        #1;
        chk("t6.async_depth", int'(depth), 0);
        chk("t6.async_empty", int'(empty), 1);
        @(negedge CLK);
        Reset = 1'b1;
        cmd(2'b01, 1'b0, 2'd0, 16'h0000);
        chk("t6.underflow", int'(underflow), 1);

        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
